// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - pipeline stage register with one-entry skid buffer, flush and stall counter
// Upstream ready is registered-state derived, so a full skid slot is what absorbs the stall.
module pipe_skid_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             ctrl_reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cycles
);

  logic             r_main_v;
  logic [WIDTH-1:0] r_main_d;
  logic             r_skid_v;
  logic [WIDTH-1:0] r_skid_d;
  logic [CNT_W-1:0] r_stall;

  logic w_in_ready;
  logic w_acc;
  logic w_pop;

  assign w_in_ready = !r_skid_v && !flush && !ctrl_reset;
  assign w_acc      = in_valid && w_in_ready;
  assign w_pop      = r_main_v && out_ready;

  always_ff @(posedge clk) begin
    if (ctrl_reset) begin
      r_main_v <= 1'b0;
      r_main_d <= NOP_VALUE;
      r_skid_v <= 1'b0;
      r_skid_d <= NOP_VALUE;
      r_stall  <= '0;
    end else begin
      // Flush squashes entries but keeps the debug counter running.
      if (r_main_v && !out_ready && (r_stall != {CNT_W{1'b1}}))
        r_stall <= r_stall + 1'b1;

      if (flush) begin
        r_main_v <= 1'b0;
        r_main_d <= NOP_VALUE;
        r_skid_v <= 1'b0;
        r_skid_d <= NOP_VALUE;
      end else if (w_pop) begin
        if (r_skid_v) begin
          r_main_d <= r_skid_d;
          r_skid_v <= 1'b0;
          r_skid_d <= NOP_VALUE;
        end else if (w_acc) begin
          r_main_d <= in_data;
        end else begin
          r_main_v <= 1'b0;
          r_main_d <= NOP_VALUE;
        end
      end else if (w_acc) begin
        if (!r_main_v) begin
          r_main_v <= 1'b1;
          r_main_d <= in_data;
        end else begin
          r_skid_v <= 1'b1;
          r_skid_d <= in_data;
        end
      end
    end
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = r_main_v;
  assign out_data     = r_main_d;
  assign occupancy    = {1'b0, r_main_v} + {1'b0, r_skid_v};
  assign stall_cycles = r_stall;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - scoreboard bench for pipe_skid_reg
module tb_pipe_skid_reg;
  localparam int               WIDTH = 16;
  localparam logic [WIDTH-1:0] NOP   = 16'hDEAD;
  localparam int               CNT_W = 4;
  localparam int               SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             ctrl_reset = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cycles;

  pipe_skid_reg #(.WIDTH(WIDTH), .NOP_VALUE(NOP), .CNT_W(CNT_W)) dut (
    .clk(clk), .ctrl_reset(ctrl_reset), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int m_occ  = 0;
  int m_stall = 0;
  bit armed  = 1'b0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] seq = 16'h0100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every delivered output is matched against the oldest accepted payload.
  always @(negedge clk) begin
    if (armed) begin
      chk("skid_implies_main", 32'(!(dut.r_skid_v && !dut.r_main_v)), 32'd1);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_pop: got %0h expected no output", out_data);
        end else begin
          chk("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic cycle(input logic rst, input logic fl, input logic iv,
                       input logic [WIDTH-1:0] d, input logic ordy);
    int pop;
    int acc;
    @(posedge clk); #1;
    ctrl_reset = rst; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    @(negedge clk); #1;
    if (armed) begin
      chk("in_ready", 32'(in_ready), 32'((m_occ < 2) && !fl && !rst));
      chk("occupancy", 32'(occupancy), 32'(m_occ));
      chk("out_valid", 32'(out_valid), 32'(m_occ > 0));
      chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
      if (m_occ == 0) chk("out_data_nop", 32'(out_data), 32'(NOP));
    end
    if (rst) begin
      exp_q.delete(); m_occ = 0; m_stall = 0; armed = 1'b1;
    end else begin
      if (m_occ > 0 && !ordy && m_stall < SAT) m_stall++;
      if (fl) begin
        exp_q.delete(); m_occ = 0;
      end else begin
        pop = (m_occ > 0 && ordy) ? 1 : 0;
        acc = (iv && m_occ < 2) ? 1 : 0;
        if (acc == 1) exp_q.push_back(d);
        m_occ = m_occ - pop + acc;
      end
    end
  endtask

  initial begin
    cycle(1, 0, 0, 16'h0, 0);
    cycle(1, 0, 0, 16'h0, 0);
    cycle(0, 0, 0, 16'h0, 0);
    // streaming
    for (int k = 1; k <= 4; k++) cycle(0, 0, 1, 16'(k), 1);
    cycle(0, 0, 0, 16'h0, 1);
    cycle(0, 0, 0, 16'h0, 1);
    // backpressure into skid, extra offer rejected
    cycle(0, 0, 1, 16'h000A, 0);
    cycle(0, 0, 1, 16'h000B, 0);
    cycle(0, 0, 1, 16'h000C, 0);
    cycle(0, 0, 0, 16'h0, 0);
    cycle(0, 0, 0, 16'h0, 1);
    cycle(0, 0, 0, 16'h0, 1);
    cycle(0, 0, 0, 16'h0, 1);
    // flush with a full stage and a concurrent offer
    cycle(0, 0, 1, 16'h0011, 0);
    cycle(0, 0, 1, 16'h0022, 0);
    cycle(0, 1, 1, 16'h0033, 0);
    cycle(0, 0, 0, 16'h0, 1);
    cycle(0, 0, 0, 16'h0, 1);
    // reset has priority over flush
    cycle(0, 0, 1, 16'h0044, 0);
    cycle(0, 0, 1, 16'h0045, 0);
    cycle(1, 1, 1, 16'h0046, 1);
    cycle(0, 0, 0, 16'h0, 1);
    cycle(0, 0, 0, 16'h0, 1);
    // counter saturation
    cycle(0, 0, 1, 16'h0055, 0);
    for (int k = 0; k < 20; k++) cycle(0, 0, 0, 16'h0, 0);
    cycle(0, 0, 0, 16'h0, 1);
    cycle(0, 0, 0, 16'h0, 1);
    // random traffic
    for (int i = 0; i < 10000; i++) begin
      logic rst, fl, iv, ordy;
      rst  = ($urandom % 500) == 0;
      fl   = ($urandom % 40) == 0;
      iv   = ($urandom % 4) != 0;
      ordy = ($urandom % 3) != 0;
      seq  = seq + 16'd1;
      cycle(rst, fl, iv, seq, ordy);
    end
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 16'h0, 1);
    chk("drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
